uart_rx_param: RTL and testbench

- Parametrised next-generation UART receiver for the UART subsystem; drops in where the fixed 8N1 receiver sits, behind the loopback or an external pin.
- Adds:
  - runtime baud divisor
  - configurable data width, parity and stop bits
  - 3-sample majority vote and false-start rejection
  - parity, framing and break detection
  - a small show-ahead FIFO with valid/ready output and overrun reporting.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_param_if.sv | 13 +
 rtl/uart_rx_fifo.sv | 50 +++++
 rtl/uart_rx_param.sv | 167 ++++++++++++++++
 tb/tb_uart_rx_param.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the parametrised UART receiver
package uart_pkg;

    localparam int unsigned MAJ_SAMPLES = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } rx_state_e;

    typedef struct packed {
        logic pe;
        logic fe;
    } rx_status_t;

    function automatic logic majority(input logic [MAJ_SAMPLES-1:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// rtl/uart_rx_param_if.sv - receive-side valid/ready stream carrying data and error flags
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 parity_err;
    logic                 frame_err;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (output rx_data, parity_err, frame_err, rx_valid, input rx_ready);
    modport slave  (input rx_data, parity_err, frame_err, rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - generic synchronous show-ahead FIFO with push/pop/full/empty
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    // A pop on an empty FIFO is ignored; a full FIFO still accepts when it pops.
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - oversampling UART receiver with runtime framing config and receive FIFO
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 two_stop,
    input  logic                 rxd,
    uart_rx_param_if.master      rx,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 busy
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS);
    localparam int EW = DATA_BITS + 2;
    localparam logic [SW-1:0] SC_LO  = SW'(OVERSAMPLE/2 - 1);
    localparam logic [SW-1:0] SC_MID = SW'(OVERSAMPLE/2);
    localparam logic [SW-1:0] SC_HI  = SW'(OVERSAMPLE/2 + 1);
    localparam logic [SW-1:0] SC_END = SW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

    rx_state_e            state, state_next;
    logic                 rxd_meta, rs;
    logic [DIV_WIDTH-1:0] div_max, tick_cnt;
    logic                 tick, start_edge;
    logic [SW-1:0]        sc;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg, hold_data;
    logic                 samp_lo, samp_mid, vote, fe_final;
    logic                 par_en_l, par_odd_l, two_stop_l, par_bit, armed;
    rx_status_t           status, head_st;
    logic                 done, brk, pop, fifo_full, fifo_empty;
    logic [EW-1:0]        head;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_meta <= 1'b1;
            rs       <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rs       <= rxd_meta;
        end
    end

    assign div_max    = (baud_div == '0) ? DIV_ONE : baud_div;
    assign tick       = (tick_cnt >= div_max - DIV_ONE);
    assign start_edge = (state == S_IDLE) && armed && !rs;
    assign vote       = majority({samp_lo, samp_mid, rs});
    assign fe_final   = status.fe | ~vote;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (armed && !rs) state_next = S_START;
            S_START:  if (tick) begin
                          if (sc == SC_HI && vote) state_next = S_IDLE;
                          else if (sc == SC_END)   state_next = S_DATA;
                      end
            S_DATA:   if (tick && sc == SC_END && bit_idx == IDX_LAST)
                          state_next = par_en_l ? S_PARITY : S_STOP1;
            S_PARITY: if (tick && sc == SC_END) state_next = S_STOP1;
            S_STOP1:  if (tick) begin
                          if (!two_stop_l && sc == SC_HI)     state_next = S_IDLE;
                          else if (two_stop_l && sc == SC_END) state_next = S_STOP2;
                      end
            S_STOP2:  if (tick && sc == SC_HI) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Frames complete at the middle of the last stop bit so the next start edge can resync.
    always_comb begin
        busy = (state != S_IDLE);
        done = tick && (sc == SC_HI) &&
               ((state == S_STOP1 && !two_stop_l) || state == S_STOP2);
        brk  = done && fe_final && (shreg == '0) && !(par_en_l && par_bit);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt   <= '0;
            sc         <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            samp_lo    <= 1'b1;
            samp_mid   <= 1'b1;
            par_en_l   <= 1'b0;
            par_odd_l  <= 1'b0;
            two_stop_l <= 1'b0;
            par_bit    <= 1'b0;
            status     <= '0;
            armed      <= 1'b1;
            hold_data  <= '0;
        end else begin
            tick_cnt <= (start_edge || tick) ? '0 : tick_cnt + DIV_ONE;
            if (start_edge) begin
                sc         <= '0;
                bit_idx    <= '0;
                status     <= '0;
                par_bit    <= 1'b0;
                par_en_l   <= parity_en;
                par_odd_l  <= parity_odd;
                two_stop_l <= two_stop;
            end else if (tick && state != S_IDLE) begin
                sc <= (sc == SC_END) ? '0 : sc + SW'(1);
                if (sc == SC_LO)  samp_lo  <= rs;
                if (sc == SC_MID) samp_mid <= rs;
                if (sc == SC_HI) begin
                    case (state)
                        S_DATA:   shreg <= {vote, shreg[DATA_BITS-1:1]};
                        S_PARITY: begin
                            par_bit   <= vote;
                            status.pe <= vote ^ (^shreg) ^ par_odd_l;
                        end
                        S_STOP1, S_STOP2: status.fe <= fe_final;
                        default: ;
                    endcase
                end
                if (state == S_DATA && sc == SC_END) bit_idx <= bit_idx + IW'(1);
            end
            // A break leaves the line low; re-arm only once it has been seen high again.
            if (brk)              armed <= 1'b0;
            else if (tick && rs)  armed <= 1'b1;
            if (!fifo_empty) hold_data <= head[DATA_BITS-1:0];
        end
    end

    assign pop = !fifo_empty && rx.rx_ready;

    uart_rx_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (done),
        .push_data ({status.pe, fe_final, shreg}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_st       = rx_status_t'(head[EW-1 -: 2]);
    assign rx.rx_valid   = !fifo_empty;
    assign rx.rx_data    = fifo_empty ? hold_data : head[DATA_BITS-1:0];
    assign rx.parity_err = !fifo_empty && head_st.pe;
    assign rx.frame_err  = !fifo_empty && head_st.fe;
    assign overrun       = done && fifo_full && !pop;
    assign break_det     = brk;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed self-checking bench for uart_rx_param
module tb_uart_rx_param;

    localparam int BP = 48;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] baud_div;
    logic        parity_en, parity_odd, two_stop, rxd;
    logic        overrun, break_det, busy;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int t_start = 0;
    int valid_rise_cyc = 0;
    int ovr_cnt = 0, brk_cnt = 0, busy_rise = 0;
    int base;
    logic busy_q = 1'b0, valid_q = 1'b0, busy_at_rise = 1'b1;

    uart_rx_param_if #(.DATA_BITS(8)) rx_if ();

    uart_rx_param #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16),
        .DIV_WIDTH  (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .baud_div   (baud_div),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .two_stop   (two_stop),
        .rxd        (rxd),
        .rx         (rx_if),
        .overrun    (overrun),
        .break_det  (break_det),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (overrun)          ovr_cnt++;
        if (break_det)        brk_cnt++;
        if (busy && !busy_q)  busy_rise++;
        if (rx_if.rx_valid && !valid_q) begin
            valid_rise_cyc = cyc;
            busy_at_rise   = busy;
        end
        busy_q  = busy;
        valid_q = rx_if.rx_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (BP) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par, input logic pbit, input int nstop);
        t_start = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (par) send_bit(pbit);
        for (int i = 0; i < nstop; i++) send_bit(1'b1);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] d, input logic pe, input logic fe);
        chk({tag, "_valid"}, rx_if.rx_valid, 1);
        chk({tag, "_data"}, rx_if.rx_data, d);
        chk({tag, "_pe"}, rx_if.parity_err, pe);
        chk({tag, "_fe"}, rx_if.frame_err, fe);
        rx_if.rx_ready = 1'b1;
        @(negedge clk);
        rx_if.rx_ready = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        rxd = 1'b1;
        baud_div = 16'd3;
        parity_en = 1'b0;
        parity_odd = 1'b0;
        two_stop = 1'b0;
        rx_if.rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", rx_if.rx_valid, 0);
        chk("rst_data", rx_if.rx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pe", rx_if.parity_err, 0);
        chk("rst_fe", rx_if.frame_err, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_brk", break_det, 0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // 8N1 0xA5: 2 sync + 1 detect + 3*(153+1) ticks -> valid visible 465 clk after start edge
        send_frame(8'hA5, 0, 1'b0, 1);
        repeat (20) @(negedge clk);
        chk("a5_latency", valid_rise_cyc - t_start, 465);
        chk("a5_busy_at_valid", busy_at_rise, 0);
        pop_chk("a5", 8'hA5, 1'b0, 1'b0);
        chk("a5_empty", rx_if.rx_valid, 0);

        // even parity on 0x07 (three ones) requires parity bit 1
        parity_en = 1'b1;
        parity_odd = 1'b0;
        send_frame(8'h07, 1, 1'b0, 1);
        send_frame(8'h07, 1, 1'b1, 1);
        repeat (20) @(negedge clk);
        pop_chk("par_bad", 8'h07, 1'b1, 1'b0);
        pop_chk("par_ok", 8'h07, 1'b0, 1'b0);
        parity_en = 1'b0;

        base = busy_rise;
        rxd = 1'b0;
        repeat (20) @(negedge clk);
        rxd = 1'b1;
        repeat (100) @(negedge clk);
        chk("glitch_busy", busy, 0);
        chk("glitch_valid", rx_if.rx_valid, 0);
        chk("glitch_busy_pulse", busy_rise - base, 1);
        send_frame(8'h3C, 0, 1'b0, 1);
        repeat (20) @(negedge clk);
        pop_chk("after_glitch", 8'h3C, 1'b0, 1'b0);

        base = ovr_cnt;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 1'b0, 1);
        repeat (20) @(negedge clk);
        chk("ovr_pulses", ovr_cnt - base, 1);
        for (int i = 1; i <= 4; i++) pop_chk("ovr_pop", 8'(i), 1'b0, 1'b0);
        chk("ovr_empty", rx_if.rx_valid, 0);
        chk("hold_last_data", rx_if.rx_data, 8'h04);

        base = brk_cnt;
        rxd = 1'b0;
        repeat (2 * 10 * BP) @(negedge clk);
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        chk("brk_pulses", brk_cnt - base, 1);
        pop_chk("brk", 8'h00, 1'b0, 1'b1);
        chk("brk_single", rx_if.rx_valid, 0);

        two_stop = 1'b1;
        for (int i = 0; i < 3; i++) send_frame(8'hFF, 0, 1'b0, 2);
        repeat (20) @(negedge clk);
        pop_chk("ts1", 8'hFF, 1'b0, 1'b0);
        pop_chk("ts2", 8'hFF, 1'b0, 1'b0);
        chk("ts3_valid", rx_if.rx_valid, 1);
        chk("ts3_data", rx_if.rx_data, 8'hFF);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        repeat (10) @(negedge clk);
        chk("mid_frame_busy", busy, 1);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst2_valid", rx_if.rx_valid, 0);
        chk("rst2_data", rx_if.rx_data, 0);
        chk("rst2_busy", busy, 0);
        chk("rst2_pe", rx_if.parity_err, 0);
        chk("rst2_fe", rx_if.frame_err, 0);
        reset_n = 1'b1;
        repeat (7 * BP + 100) @(negedge clk);
        chk("post_rst_valid", rx_if.rx_valid, 0);
        chk("post_rst_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
